fifo_read_ctrl: RTL and testbench

Read-side controller of the camera-to-VGA asynchronous pixel FIFO. It is the counterpart of the write-side pointer/full logic and runs entirely in the VGA (read) clock domain. It synchronizes the Gray-coded write pointer and maintains the binary and Gray read pointers. It generates empty, almost_empty, a fill level and an underflow flag. It drives the read port of the dual-port RAM and returns registered pixel data with a valid strobe.

---
 rtl/fifo_read_ctrl.sv | 112 +++++++++++
 tb/tb_fifo_read_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - read-side pointer, flag and data-return logic of the async pixel FIFO
module fifo_read_ctrl #(
    parameter int PTR_WIDTH  = 9,
    parameter int DATA_WIDTH = 16,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  r_en,
    input  logic [PTR_WIDTH:0]    g_wptr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_ren,
    output logic [PTR_WIDTH-1:0]  mem_raddr,
    output logic [PTR_WIDTH:0]    b_rptr,
    output logic [PTR_WIDTH:0]    g_rptr,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    rd_level,
    output logic                  underflow
);

    localparam int PW = PTR_WIDTH + 1;
    localparam logic [PW-1:0] AE_THRESH = PW'(AE_LEVEL);

    // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wptr_s1;
    logic [PW-1:0] wptr_s2;
    logic [PW-1:0] wptr_bin;
    logic          rd_accept;
    logic [PW-1:0] b_rptr_next;
    logic [PW-1:0] g_rptr_next;
    logic [PW-1:0] level_next;
    logic          rd_pend;

    // Two-flop synchronizer; the only consumer of the foreign-domain write pointer.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            wptr_s1 <= '0;
            wptr_s2 <= '0;
        end else begin
            wptr_s1 <= g_wptr;
            wptr_s2 <= wptr_s1;
        end
    end

    // Next-pointer and level arithmetic. The level uses the post-read pointer and the
    // current synchronized write pointer so a read and a write in the same cycle net out.
    always_comb begin
        rd_accept   = r_en & ~empty;
        b_rptr_next = b_rptr + {{PTR_WIDTH{1'b0}}, rd_accept};
        g_rptr_next = (b_rptr_next >> 1) ^ b_rptr_next;
        wptr_bin    = gray2bin(wptr_s2);
        level_next  = wptr_bin - b_rptr_next;
    end

    assign mem_ren   = rd_accept;
    assign mem_raddr = b_rptr[PTR_WIDTH-1:0];

    // Pointer and flag registers. Flags only see the write side through the synchronizer,
    // so they can lag (stay empty longer) but never release early.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            b_rptr       <= '0;
            g_rptr       <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
        end else begin
            b_rptr       <= b_rptr_next;
            g_rptr       <= g_rptr_next;
            empty        <= (g_rptr_next == wptr_s2);
            almost_empty <= (level_next <= AE_THRESH);
            rd_level     <= level_next;
        end
    end

    // Return path: the RAM answers one edge after the accept, we register it on the next edge.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd_pend <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            rd_pend <= rd_accept;
            r_valid <= rd_pend;
            if (rd_pend) begin
                r_data <= mem_rdata;
            end
        end
    end

    // Sticky underflow: a request while empty is dropped and remembered until reset.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            underflow <= 1'b0;
        end else if (r_en && empty) begin
            underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - directed self-checking bench for fifo_read_ctrl
module tb_fifo_read_ctrl;

    localparam int PTR_WIDTH  = 3;
    localparam int DATA_WIDTH = 16;
    localparam int AE_LEVEL   = 4;

    logic                  rclk = 1'b0;
    logic                  rrst_n = 1'b1;
    logic                  r_en = 1'b0;
    logic [PTR_WIDTH:0]    g_wptr = '0;
    logic [DATA_WIDTH-1:0] mem_rdata = '0;
    logic                  mem_ren;
    logic [PTR_WIDTH-1:0]  mem_raddr;
    logic [PTR_WIDTH:0]    b_rptr;
    logic [PTR_WIDTH:0]    g_rptr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  empty;
    logic                  almost_empty;
    logic [PTR_WIDTH:0]    rd_level;
    logic                  underflow;

    int n_assert = 0;
    int n_fail   = 0;

    fifo_read_ctrl #(
        .PTR_WIDTH (PTR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .AE_LEVEL  (AE_LEVEL)
    ) dut (
        .rclk        (rclk),
        .rrst_n      (rrst_n),
        .r_en        (r_en),
        .g_wptr      (g_wptr),
        .mem_rdata   (mem_rdata),
        .mem_ren     (mem_ren),
        .mem_raddr   (mem_raddr),
        .b_rptr      (b_rptr),
        .g_rptr      (g_rptr),
        .r_data      (r_data),
        .r_valid     (r_valid),
        .empty       (empty),
        .almost_empty(almost_empty),
        .rd_level    (rd_level),
        .underflow   (underflow)
    );

    always #5 rclk = ~rclk;

    // Synchronous RAM model: word at address a holds 0xA0 + a.
    always @(posedge rclk) begin
        if (mem_ren) mem_rdata <= 16'h00A0 + 16'(mem_raddr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge rclk);
    endtask

    initial begin
        // 1. asynchronous reset mid-cycle
        #3 rrst_n = 1'b0;
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        chk("rst_level", 32'(rd_level), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_rvalid", 32'(r_valid), 32'd0);
        chk("rst_rdata", 32'(r_data), 32'd0);
        chk("rst_brptr", 32'(b_rptr), 32'd0);
        chk("rst_grptr", 32'(g_rptr), 32'd0);
        chk("rst_memren", 32'(mem_ren), 32'd0);
        tick(2);
        rrst_n = 1'b1;

        // 2. write pointer sync latency: gray(3)
        g_wptr = 4'b0010;
        tick(2);
        chk("sync_empty_e2", 32'(empty), 32'd1);
        chk("sync_level_e2", 32'(rd_level), 32'd0);
        tick(1);
        chk("sync_empty_e3", 32'(empty), 32'd0);
        chk("sync_level_e3", 32'(rd_level), 32'd3);
        chk("sync_aempty_e3", 32'(almost_empty), 32'd1);

        // 3. read latency, drain and underflow
        r_en = 1'b1;
        #1;
        chk("rd_memren0", 32'(mem_ren), 32'd1);
        chk("rd_addr0", 32'(mem_raddr), 32'd0);
        tick(1);
        chk("rd_addr1", 32'(mem_raddr), 32'd1);
        chk("rd_valid_a", 32'(r_valid), 32'd0);
        chk("rd_brptr_a", 32'(b_rptr), 32'd1);
        tick(1);
        chk("rd_addr2", 32'(mem_raddr), 32'd2);
        chk("rd_valid_b", 32'(r_valid), 32'd1);
        chk("rd_data_b", 32'(r_data), 32'h00A0);
        tick(1);
        chk("rd_empty_c", 32'(empty), 32'd1);
        chk("rd_level_c", 32'(rd_level), 32'd0);
        chk("rd_memren_c", 32'(mem_ren), 32'd0);
        chk("rd_valid_c", 32'(r_valid), 32'd1);
        chk("rd_data_c", 32'(r_data), 32'h00A1);
        chk("rd_uflow_c", 32'(underflow), 32'd0);
        tick(1);
        chk("rd_uflow_d", 32'(underflow), 32'd1);
        chk("rd_brptr_d", 32'(b_rptr), 32'd3);
        chk("rd_valid_d", 32'(r_valid), 32'd1);
        chk("rd_data_d", 32'(r_data), 32'h00A2);
        r_en = 1'b0;
        tick(1);
        chk("rd_valid_e", 32'(r_valid), 32'd0);
        chk("rd_hold_e", 32'(r_data), 32'h00A2);
        chk("rd_uflow_sticky", 32'(underflow), 32'd1);

        // 4. full depth and wrap
        g_wptr = 4'b0000;
        rrst_n = 1'b0;
        tick(1);
        rrst_n = 1'b1;
        g_wptr = 4'b1100;
        tick(3);
        chk("full_level", 32'(rd_level), 32'd8);
        chk("full_aempty", 32'(almost_empty), 32'd0);
        chk("full_empty", 32'(empty), 32'd0);
        r_en = 1'b1;
        tick(8);
        r_en = 1'b0;
        chk("full_brptr", 32'(b_rptr), 32'd8);
        chk("full_grptr", 32'(g_rptr), 32'b1100);
        chk("full_empty_after", 32'(empty), 32'd1);
        chk("full_uflow", 32'(underflow), 32'd0);
        g_wptr = 4'b1000;
        tick(3);
        chk("wrap_level7", 32'(rd_level), 32'd7);
        r_en = 1'b1;
        tick(7);
        r_en = 1'b0;
        chk("wrap_brptr15", 32'(b_rptr), 32'd15);
        chk("wrap_grptr15", 32'(g_rptr), 32'b1000);
        g_wptr = 4'b0000;
        tick(3);
        chk("wrap_level1", 32'(rd_level), 32'd1);
        r_en = 1'b1;
        tick(1);
        r_en = 1'b0;
        chk("wrap_brptr0", 32'(b_rptr), 32'd0);
        chk("wrap_grptr0", 32'(g_rptr), 32'b0000);
        chk("wrap_empty", 32'(empty), 32'd1);
        chk("wrap_uflow", 32'(underflow), 32'd0);

        // 5. read accepted in the cycle the synchronized write pointer advances
        g_wptr = 4'b0011;
        tick(3);
        chk("sim_level2", 32'(rd_level), 32'd2);
        g_wptr = 4'b0010;
        tick(2);
        chk("sim_level_pre", 32'(rd_level), 32'd2);
        r_en = 1'b1;
        tick(1);
        r_en = 1'b0;
        chk("sim_level_post", 32'(rd_level), 32'd2);
        chk("sim_brptr", 32'(b_rptr), 32'd1);
        chk("sim_empty", 32'(empty), 32'd0);
        chk("sim_uflow", 32'(underflow), 32'd0);

        // 6. reset during a back-to-back burst
        g_wptr = 4'b0100;
        tick(3);
        chk("burst_level", 32'(rd_level), 32'd6);
        r_en = 1'b1;
        tick(3);
        chk("burst_valid", 32'(r_valid), 32'd1);
        #2 rrst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(r_valid), 32'd0);
        chk("mid_rst_brptr", 32'(b_rptr), 32'd0);
        chk("mid_rst_grptr", 32'(g_rptr), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        tick(1);
        r_en = 1'b0;
        rrst_n = 1'b1;
        tick(1);
        chk("post_rst_valid", 32'(r_valid), 32'd0);
        chk("post_rst_empty", 32'(empty), 32'd1);
        chk("post_rst_uflow", 32'(underflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
